// File: rtl/lc3_mem_arbiter.sv
// Two-port arbiter/sequencer for the LC3 single-port memory (CPU path + loader/debug port).
// Define LC3_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the CPU always wins ties.
`timescale 1ns/1ps
module lc3_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

`ifdef LC3_ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    localparam logic [2:0] LatInit = 3'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t              state;
    state_t              stateNext;
    logic                ownerLd;
    logic                latWe;
    logic [ADDR_W-1:0]   latAddr;
    logic [DATA_W-1:0]   latWdata;
    logic [2:0]          cnt;
    logic                lastGrantLd;
    logic [DATA_W-1:0]   rdataReg;
    logic                grant;
    logic                grantLd;

    // On a tie, round-robin favours whoever was not served last; fixed priority favours the CPU.
    function automatic logic tieToLoader(input logic lastLd);
        return RoundRobin ? !lastLd : 1'b0;
    endfunction

    always_comb begin
        grant     = 1'b0;
        grantLd   = 1'b0;
        stateNext = state;
        cpu_ack   = 1'b0;
        ld_ack    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && ld_req) begin
                    grant   = 1'b1;
                    grantLd = tieToLoader(lastGrantLd);
                end else if (cpu_req) begin
                    grant   = 1'b1;
                end else if (ld_req) begin
                    grant   = 1'b1;
                    grantLd = 1'b1;
                end
                if (grant) stateNext = ACCESS;
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = latWe;
                stateNext = latWe ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == 3'd1) stateNext = RESP;
            end
            RESP: begin
                cpu_ack   = !ownerLd;
                ld_ack    = ownerLd;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ownerLd     <= 1'b0;
            latWe       <= 1'b0;
            latAddr     <= '0;
            latWdata    <= '0;
            cnt         <= '0;
            lastGrantLd <= 1'b1;
            rdataReg    <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (grant) begin
                        ownerLd  <= grantLd;
                        latWe    <= grantLd ? ld_we : cpu_we;
                        latAddr  <= grantLd ? ld_addr : cpu_addr;
                        latWdata <= grantLd ? ld_wdata : cpu_wdata;
                    end
                end
                ACCESS: begin
                    if (!latWe) cnt <= LatInit;
                end
                WAIT: begin
                    // Memory data is valid in the last WAIT cycle, when the count reaches 1.
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) rdataReg <= mem_rdata;
                end
                RESP: begin
                    lastGrantLd <= ownerLd;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = latAddr;
    assign mem_wdata = latWdata;
    assign rdata     = rdataReg;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: a driver predicts ack order, timing and data from a
// transaction-level memory model; a negedge monitor compares what the DUT presents.
`timescale 1ns/1ps
module tb_lc3_mem_arbiter;
    localparam int LAT = 3;
`ifdef LC3_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack;
    logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
    logic        ld_req = 1'b0, ld_we = 1'b0, ld_ack;
    logic [15:0] ld_addr = 16'h0, ld_wdata = 16'h0;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, busy;

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit we; logic [15:0] addr; logic [15:0] wd; } txn_t;
    typedef struct { int cyc; bit isLd; logic [15:0] rd; } ackExp_t;
    typedef struct { int cyc; bit we; logic [15:0] addr; logic [15:0] wd; int waitN; } accExp_t;
    typedef struct { int cyc; bit busy; logic [15:0] rd; bit chkAddr; logic [15:0] addr; } stExp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          monEn = 1'b0;
    ackExp_t     ackQ[$];
    accExp_t     accQ[$];
    stExp_t      stQ[$];
    logic [15:0] refMem [0:65535];
    logic [15:0] refRd = 16'h0;
    bit          refLastGrantLd = 1'b1;

    // Memory environment: writes commit at the ACCESS edge, read data appears LAT cycles later.
    logic [15:0] envMem [0:65535];
    logic        pv [1:LAT];
    logic [15:0] pa [1:LAT];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        pv[1] <= mem_en && !mem_we;
        pa[1] <= mem_addr;
        for (int i = 2; i <= LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
        if (mem_en && mem_we) envMem[mem_addr] <= mem_wdata;
    end

    assign mem_rdata = pv[LAT] ? envMem[pa[LAT]] : 16'hDEAD;

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic txn_t mk(input bit we, input logic [15:0] addr, input logic [15:0] wd);
        txn_t t;
        t.we = we;
        t.addr = addr;
        t.wd = wd;
        return t;
    endfunction

    int          holdFrom = 1;
    int          holdTo = 0;
    logic [15:0] holdAddr = 16'h0;

    initial begin
        ackExp_t ae;
        accExp_t ce;
        stExp_t  se;
        forever begin
            @(negedge clk);
            if (monEn) begin
                if (cpu_ack || ld_ack) begin
                    check("single_ack", int'(cpu_ack & ld_ack), 0);
                    check("ack_expected", int'(ackQ.size() > 0), 1);
                    if (ackQ.size() > 0) begin
                        ae = ackQ.pop_front();
                        check("ack_owner_is_ld", int'(ld_ack), int'(ae.isLd));
                        check("ack_cycle", cyc, ae.cyc);
                        check("ack_rdata", int'(rdata), int'(ae.rd));
                    end
                end else if (ackQ.size() > 0 && ackQ[0].cyc < cyc) begin
                    check("ack_present", int'(cpu_ack | ld_ack), 1);
                    ae = ackQ.pop_front();
                end

                if (mem_en) begin
                    check("access_expected", int'(accQ.size() > 0), 1);
                    if (accQ.size() > 0) begin
                        ce = accQ.pop_front();
                        check("access_cycle", cyc, ce.cyc);
                        check("access_we", int'(mem_we), int'(ce.we));
                        check("access_addr", int'(mem_addr), int'(ce.addr));
                        if (ce.we) check("access_wdata", int'(mem_wdata), int'(ce.wd));
                        holdFrom = cyc + 1;
                        holdTo = cyc + ce.waitN;
                        holdAddr = ce.addr;
                    end
                end else begin
                    if (mem_we) check("we_needs_en", int'(mem_en), 1);
                    if (accQ.size() > 0 && accQ[0].cyc < cyc) begin
                        check("access_present", int'(mem_en), 1);
                        ce = accQ.pop_front();
                    end
                    if (cyc >= holdFrom && cyc <= holdTo) begin
                        check("wait_addr", int'(mem_addr), int'(holdAddr));
                        check("wait_we", int'(mem_we), 0);
                    end
                end

                if (stQ.size() > 0 && stQ[0].cyc <= cyc) begin
                    se = stQ.pop_front();
                    check("state_busy", int'(busy), int'(se.busy));
                    check("state_rdata", int'(rdata), int'(se.rd));
                    if (se.chkAddr) begin
                        check("state_mem_addr", int'(mem_addr), int'(se.addr));
                        check("state_mem_en", int'(mem_en), 0);
                    end
                end
            end
        end
    end

    // Reference arbitration for one grant: a lone requester wins; a tie goes to the CPU
    // unless round-robin is enabled and the CPU was served last.
    task automatic predictStep(input int t, input bit pc, input txn_t tc, input bit pl,
                               input txn_t tl, output bit winLd, output int ackc);
        txn_t tx;
        winLd = pl && (!pc || (RR && !refLastGrantLd));
        tx = winLd ? tl : tc;
        if (tx.we) begin
            refMem[tx.addr] = tx.wd;
            ackc = t + 2;
        end else begin
            refRd = refMem[tx.addr];
            ackc = t + 2 + LAT;
        end
        accQ.push_back('{t + 1, tx.we, tx.addr, tx.wd, tx.we ? 0 : LAT});
        ackQ.push_back('{ackc, winLd, refRd});
        refLastGrantLd = winLd;
    endtask

    task automatic runGroup(input bit useC, input txn_t tc, input bit useL, input txn_t tl,
                            input bit chkPre);
        int t, ackc, to;
        bit w, pc, pl, sawC, sawL;
        logic [15:0] rdBefore;
        @(posedge clk); #1;
        t = cyc;
        rdBefore = refRd;
        if (useC) begin
            cpu_req = 1'b1; cpu_we = tc.we; cpu_addr = tc.addr; cpu_wdata = tc.wd;
        end
        if (useL) begin
            ld_req = 1'b1; ld_we = tl.we; ld_addr = tl.addr; ld_wdata = tl.wd;
        end
        pc = useC;
        pl = useL;
        ackc = t;
        while (pc || pl) begin
            predictStep(t, pc, tc, pl, tl, w, ackc);
            if (w) pl = 1'b0; else pc = 1'b0;
            t = ackc + 1;
        end
        if (chkPre) stQ.push_back('{ackc - 1, 1'b1, rdBefore, 1'b0, 16'h0});
        pc = useC;
        pl = useL;
        to = 0;
        while ((pc || pl) && to < 60) begin
            @(negedge clk);
            sawC = cpu_ack;
            sawL = ld_ack;
            @(posedge clk); #1;
            if (sawC && pc) begin cpu_req = 1'b0; pc = 1'b0; end
            if (sawL && pl) begin ld_req = 1'b0; pl = 1'b0; end
            to++;
        end
        check("group_done", int'(pc) + int'(pl), 0);
        if (!(pc || pl)) stQ.push_back('{cyc, 1'b0, refRd, 1'b0, 16'h0});
        else begin
            cpu_req = 1'b0;
            ld_req = 1'b0;
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        ld_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        refRd = 16'h0;
        refLastGrantLd = 1'b1;
        stQ.push_back('{cyc, 1'b0, 16'h0, 1'b1, 16'h0});
    endtask

    initial begin
        int t, ackc, n, to;
        bit w;
        txn_t tc, tl;

        doReset();
        monEn = 1'b1;

        for (int i = 0; i < 16; i++)
            runGroup(1'b0, tc, 1'b1, mk(1'b1, 16'(i), 16'($urandom)), 1'b0);

        runGroup(1'b0, tc, 1'b1, mk(1'b1, 16'h3000, 16'h1234), 1'b0);
        runGroup(1'b0, tc, 1'b1, mk(1'b0, 16'h3000, 16'h0), 1'b0);
        runGroup(1'b0, tc, 1'b1, mk(1'b1, 16'h0005, 16'hBEEF), 1'b0);
        runGroup(1'b1, mk(1'b0, 16'h0005, 16'h0), 1'b0, tl, 1'b0);

        doReset();
        runGroup(1'b1, mk(1'b0, 16'h3000, 16'h0), 1'b1, mk(1'b0, 16'h0005, 16'h0), 1'b0);

        // Both requesters hold req high across four transactions.
        doReset();
        @(posedge clk); #1;
        t = cyc;
        tc = mk(1'b1, 16'h0020, 16'hC0C0);
        tl = mk(1'b1, 16'h0021, 16'h1D1D);
        cpu_req = 1'b1; cpu_we = tc.we; cpu_addr = tc.addr; cpu_wdata = tc.wd;
        ld_req = 1'b1; ld_we = tl.we; ld_addr = tl.addr; ld_wdata = tl.wd;
        for (int k = 0; k < 4; k++) begin
            predictStep(t, 1'b1, tc, 1'b1, tl, w, ackc);
            t = ackc + 1;
        end
        n = 0;
        to = 0;
        while (n < 4 && to < 80) begin
            @(negedge clk);
            if (cpu_ack || ld_ack) n++;
            @(posedge clk); #1;
            to++;
        end
        cpu_req = 1'b0;
        ld_req = 1'b0;
        check("continuous_acks", n, 4);
        stQ.push_back('{cyc, 1'b0, refRd, 1'b0, 16'h0});

        // Reset lands in the first WAIT cycle of a CPU read.
        @(posedge clk); #1;
        t = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        accQ.push_back('{t + 1, 1'b0, 16'h0005, 16'h0, 1});
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        refRd = 16'h0;
        refLastGrantLd = 1'b1;
        stQ.push_back('{cyc, 1'b0, 16'h0, 1'b1, 16'h0});
        repeat (8) @(posedge clk);

        doReset();
        runGroup(1'b0, tc, 1'b1, mk(1'b1, 16'h0101, 16'h5555), 1'b0);
        runGroup(1'b1, mk(1'b1, 16'h0100, 16'hAAAA), 1'b0, tl, 1'b0);
        runGroup(1'b1, mk(1'b0, 16'h0101, 16'h0), 1'b0, tl, 1'b1);

        for (int g = 0; g < 60; g++) begin
            int kind;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            kind = $urandom_range(0, 2);
            tc = mk(1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom));
            tl = mk(1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom));
            runGroup(kind != 1, tc, kind != 0, tl, 1'b0);
        end

        repeat (10) @(posedge clk);
        check("ackq_drained", ackQ.size(), 0);
        check("accq_drained", accQ.size(), 0);
        check("stq_drained", stQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
